// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling rate, tick-counter width and the
// one-hot state encoding used by both the transmitter and the receiver.
package uart_pkg;

   localparam int unsigned OVERSAMPLE      = 16;
   localparam int unsigned TICK_W          = 4;
   localparam int unsigned IDX_W           = 3;
   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned STATE_W         = 5;

   localparam logic [STATE_W-1:0] IDLE   = 5'b00001;
   localparam logic [STATE_W-1:0] START  = 5'b00010;
   localparam logic [STATE_W-1:0] DATA   = 5'b00100;
   localparam logic [STATE_W-1:0] PARITY = 5'b01000;
   localparam logic [STATE_W-1:0] STOP   = 5'b10000;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = IDLE,
      ST_START  = START,
      ST_DATA   = DATA,
      ST_PARITY = PARITY,
      ST_STOP   = STOP
   } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial-line bundle for uart_tx; the master drives
// tick/start/data, the transmitter (slave) drives line, busy and done.
interface uart_tx_if #(
   parameter int unsigned DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH
);
   logic                  i_tick;
   logic                  i_tx_start;
   logic [DATA_WIDTH-1:0] i_data_byte;
   logic                  o_tx_serial;
   logic                  o_tx_busy;
   logic                  o_tx_done;

   modport master (
      output i_tick, i_tx_start, i_data_byte,
      input  o_tx_serial, o_tx_busy, o_tx_done
   );

   modport slave (
      input  i_tick, i_tx_start, i_data_byte,
      output o_tx_serial, o_tx_busy, o_tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity
// (UART_TX_PARITY_EN) and 1..2 stop bits, paced by a 16x oversample tick.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_WIDTH = 1
) (
   input  logic     i_clock,
   input  logic     i_reset,
   uart_tx_if.slave bus
);

   uart_state_e             state_q, state_nxt;
   logic [TICK_W-1:0]       cnt_q, cnt_nxt;
   logic [DATA_WIDTH-1:0]   shift_q, shift_nxt;
   logic [IDX_W-1:0]        idx_q, idx_nxt;
   logic                    stop_q, stop_nxt;
   logic                    serial_q, serial_nxt;
   logic                    busy_q, busy_nxt;
   logic                    done_q, done_nxt;
   logic                    bit_end;
`ifdef UART_TX_PARITY_EN
   logic                    par_q, par_nxt;
`endif

   assign bit_end = bus.i_tick && (cnt_q == TICK_W'(OVERSAMPLE - 1));

   // Next-state and datapath; outputs are derived from the next state so
   // that the registered line already shows the new bit on the following cycle.
   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      shift_nxt  = shift_q;
      idx_nxt    = idx_q;
      stop_nxt   = stop_q;
      done_nxt   = 1'b0;
      serial_nxt = 1'b1;
      busy_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt    = par_q;
`endif
      if (bus.i_tick) cnt_nxt = cnt_q + TICK_W'(1);

      case (state_q)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (bus.i_tx_start) begin
               shift_nxt = bus.i_data_byte;
               idx_nxt   = '0;
               stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_nxt   = ^bus.i_data_byte;
`endif
               state_nxt = ST_START;
            end
         end
         ST_START: if (bit_end) state_nxt = ST_DATA;
         ST_DATA: begin
            if (bit_end) begin
               shift_nxt = shift_q >> 1;
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  stop_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  idx_nxt = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (stop_q == 1'(STOP_WIDTH - 1)) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  stop_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_START:  serial_nxt = 1'b0;
         ST_DATA:   serial_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: serial_nxt = par_nxt;
`endif
         default:   serial_nxt = 1'b1;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         stop_q   <= 1'b0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         shift_q  <= shift_nxt;
         idx_q    <= idx_nxt;
         stop_q   <= stop_nxt;
         serial_q <= serial_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_nxt;
`endif
      end
   end

   assign bus.o_tx_serial = serial_q;
   assign bus.o_tx_busy   = busy_q;
   assign bus.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line monitor rebuilds each frame tick by
// tick and compares it against the words queued when each start was accepted.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P      = 1;
   localparam int STOP_W = 1;
`else
   localparam int P      = 0;
   localparam int STOP_W = 2;
`endif
   localparam int DW          = 8;
   localparam int FRAME_BITS  = 1 + DW + P + STOP_W;
   localparam int FRAME_TICKS = FRAME_BITS * 16;

   logic clk;
   logic rst_n;
   logic tick_en;
   logic tick_ph;

   int n_cmp;
   int n_err;
   int done_cnt;
   int exp_done;

   logic [7:0] exp_q[$];

   logic samples[256];
   int   mon_ticks;
   logic in_frame;

   uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx #(.DATA_WIDTH(DW), .STOP_WIDTH(STOP_W)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One tick every other clock while enabled.
   initial begin
      tick_ph = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en) begin
            tick_ph    = ~tick_ph;
            bus.i_tick = tick_ph;
         end else begin
            bus.i_tick = 1'b0;
         end
      end
   end

   task automatic finalize_frame();
      int bad;
      int stop_ok;
      logic [7:0] got_data;
      logic [7:0] exp_data;
      bad = 0;
      stop_ok = 0;
      check("frame_ticks", mon_ticks, FRAME_TICKS);
      if (mon_ticks == FRAME_TICKS) begin
         for (int b = 0; b < FRAME_BITS; b++)
            for (int t = 1; t < 16; t++)
               if (samples[b*16+t] !== samples[b*16]) bad++;
         check("bit_stable", bad, 0);
         check("start_bit", samples[0], 0);
         for (int i = 0; i < DW; i++) got_data[i] = samples[(1+i)*16];
         for (int s = 0; s < STOP_W; s++)
            if (samples[(1+DW+P+s)*16] === 1'b1) stop_ok++;
         check("stop_bits", stop_ok, STOP_W);
         check("done_pulse", bus.o_tx_done, 1);
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            exp_data = exp_q.pop_front();
            check("data", got_data, exp_data);
`ifdef UART_TX_PARITY_EN
            check("parity", samples[(1+DW)*16], ^exp_data);
`endif
         end
      end else if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
      end
   endtask

   // Frame monitor: samples the line on each consumed tick while busy.
   always @(negedge clk) begin
      if (!rst_n) begin
         if (in_frame && exp_q.size() != 0) void'(exp_q.pop_front());
         in_frame  = 1'b0;
         mon_ticks = 0;
      end else begin
         if (bus.o_tx_done) done_cnt++;
         if (bus.o_tx_busy) begin
            if (!in_frame) begin
               in_frame  = 1'b1;
               mon_ticks = 0;
            end
            if (bus.i_tick) begin
               if (mon_ticks < 256) samples[mon_ticks] = bus.o_tx_serial;
               mon_ticks++;
            end
         end else if (in_frame) begin
            in_frame = 1'b0;
            finalize_frame();
         end else if (bus.o_tx_done) begin
            check("stray_done", 1, 0);
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.o_tx_busy && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 2000) check("timeout_idle", 0, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_tx_done && n < 2000);
      if (!bus.o_tx_done) check("timeout_done", 0, 1);
   endtask

   task automatic start_frame(input logic [7:0] d);
      wait_idle();
      @(posedge clk);
      #1;
      bus.i_data_byte = d;
      bus.i_tx_start  = 1'b1;
      @(posedge clk);
      #1;
      bus.i_tx_start = 1'b0;
      exp_q.push_back(d);
      check("accept_line", bus.o_tx_serial, 0);
      check("accept_busy", bus.o_tx_busy, 1);
   endtask

   task automatic send(input logic [7:0] d);
      start_frame(d);
      wait_done();
      exp_done++;
   endtask

   initial begin
      int errs;
      n_cmp = 0; n_err = 0; done_cnt = 0; exp_done = 0;
      in_frame = 1'b0; mon_ticks = 0;
      rst_n = 1'b0; tick_en = 1'b0;
      bus.i_tick = 1'b0; bus.i_tx_start = 1'b0; bus.i_data_byte = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_line", bus.o_tx_serial, 1);
      check("rst_busy", bus.o_tx_busy, 0);
      check("rst_done", bus.o_tx_done, 0);
      rst_n = 1'b1;
      tick_en = 1'b1;
      repeat (4) @(posedge clk);

      send(8'h55);
      send(8'hA3);
      send(8'h07);

      // Start request and data change mid-frame are ignored.
      start_frame(8'h12);
      repeat (100) @(posedge clk);
      #1;
      bus.i_data_byte = 8'hFF;
      bus.i_tx_start  = 1'b1;
      @(posedge clk);
      #1;
      bus.i_tx_start = 1'b0;
      wait_done();
      exp_done++;
      @(posedge clk);
      #1;
      check("ignored_start_idle", bus.o_tx_busy, 0);

      // Start held high: back-to-back frames with the done cycle as the only gap.
      @(posedge clk);
      #1;
      bus.i_data_byte = 8'h3C;
      bus.i_tx_start  = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h3C);
      check("hold_accept", bus.o_tx_busy, 1);
      wait_done();
      exp_done++;
      @(posedge clk);
      #1;
      check("b2b_busy", bus.o_tx_busy, 1);
      check("b2b_line", bus.o_tx_serial, 0);
      exp_q.push_back(8'h3C);
      bus.i_tx_start = 1'b0;
      wait_done();
      exp_done++;

      // Tick stall in the start bit.
      start_frame(8'h5A);
      repeat (10) @(posedge clk);
      #1;
      tick_en = 1'b0;
      errs = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.o_tx_serial !== 1'b0 || bus.o_tx_busy !== 1'b1) errs++;
      end
      check("stall_hold", errs, 0);
      @(posedge clk);
      #1;
      tick_en = 1'b1;
      wait_done();
      exp_done++;

      // Asynchronous reset during data bit 3 of 0xC6 (bit 3 = 0).
      start_frame(8'hC6);
      repeat (136) @(posedge clk);
      #2;
      check("pre_rst_bit3", bus.o_tx_serial, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_line", bus.o_tx_serial, 1);
      check("async_rst_busy", bus.o_tx_busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      errs = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.o_tx_serial !== 1'b1 || bus.o_tx_busy !== 1'b0) errs++;
      end
      check("post_rst_idle", errs, 0);

      send(8'h81);

      repeat (4) @(posedge clk);
      check("done_count", done_cnt, exp_done);
      check("sb_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
